// File: rtl/pong_pkg.sv
// pong_pkg: definitions shared by the Pong match controller and the ball block.
//   match_state_t : match sequencer states (IDLE=0, SERVE=1, PLAY=2, OVER=3)
//   DIR_RIGHT/LEFT: serve direction encoding used on o_serve_dir
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } match_state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/pong_rise_detect.sv
// pong_rise_detect: registered rising-edge detector.
//   i_clk     : clock
//   i_reset_n : asynchronous active-low reset
//   i_sig     : level input (already synchronised)
//   o_rise    : high in the cycle where i_sig is 1 and its registered copy is 0
// RESET_VAL sets the registered copy on reset; 1 suppresses an edge for a
// signal that is already high when reset releases.
module pong_rise_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_sig,
    output logic o_rise
);

    logic sig_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sig_q <= RESET_VAL;
        end else begin
            sig_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~sig_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match-level sequencer for the Pong ball datapath.
// Freezes and recentres the ball for each serve, waits a serve delay in frame
// ticks, releases the ball and scores exit events until WIN_SCORE is reached.
//   i_clk, i_reset_n : pixel clock, asynchronous active-low reset
//   i_frame_tick     : one-cycle pulse per frame
//   i_start          : start button level (debounced, synchronised)
//   i_point_p1/p2    : one-cycle exit pulses, player 1 / player 2 scores
//   o_ball_run       : ball motion enable (high in PLAY)
//   o_ball_serve     : one-cycle recentre pulse, direction on o_serve_dir
//   o_score1/2       : scores
//   o_game_over      : high in OVER, o_winner valid while high
//   o_state          : current match state
// Optional feature: define PONG_AUTO_RESTART_EN to return from OVER to IDLE
// after OVER_HOLD_FRAMES frame ticks.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE          = 10,
    parameter int unsigned SERVE_DELAY_FRAMES = 60,
    parameter int unsigned OVER_HOLD_FRAMES   = 180
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_frame_tick,
    input  logic       i_start,
    input  logic       i_point_p1,
    input  logic       i_point_p2,
    output logic       o_ball_run,
    output logic       o_ball_serve,
    output logic       o_serve_dir,
    output logic [3:0] o_score1,
    output logic [3:0] o_score2,
    output logic       o_game_over,
    output logic       o_winner,
    output logic [1:0] o_state
);

    localparam int unsigned MAX_FRAMES =
        (SERVE_DELAY_FRAMES > OVER_HOLD_FRAMES) ? SERVE_DELAY_FRAMES : OVER_HOLD_FRAMES;
    localparam int unsigned CW = $clog2(MAX_FRAMES) + 1;

    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_DELAY_FRAMES - 1);
`ifdef PONG_AUTO_RESTART_EN
    localparam logic [CW-1:0] HOLD_LAST  = CW'(OVER_HOLD_FRAMES - 1);
`endif
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

    match_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    score1_q, score1_d, score2_q, score2_d;
    logic [3:0]    score1_inc, score2_inc;
    logic          dir_q, dir_d;
    logic          winner_q, winner_d;
    logic          serve_q, serve_d;
    logic          run_q, over_q;
    logic          start_rise;

    pong_rise_detect #(
        .RESET_VAL (1'b1)
    ) u_start_rise (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_sig     (i_start),
        .o_rise    (start_rise)
    );

    assign score1_inc = score1_q + 4'd1;
    assign score2_inc = score2_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        score1_d = score1_q;
        score2_d = score2_q;
        dir_d    = dir_q;
        winner_d = winner_q;
        serve_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d  = ST_SERVE;
                    score1_d = '0;
                    score2_d = '0;
                    dir_d    = DIR_RIGHT;
                    serve_d  = 1'b1;
                end
            end

            ST_SERVE: begin
                if (i_frame_tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_PLAY: begin
                if (i_point_p1 && i_point_p2) begin
                    // Simultaneous exits: replay the point with the same direction.
                    state_d = ST_SERVE;
                    serve_d = 1'b1;
                end else if (i_point_p1) begin
                    score1_d = score1_inc;
                    dir_d    = DIR_RIGHT;
                    if (score1_inc == WIN) begin
                        state_d  = ST_OVER;
                        winner_d = 1'b0;
                    end else begin
                        state_d = ST_SERVE;
                        serve_d = 1'b1;
                    end
                end else if (i_point_p2) begin
                    score2_d = score2_inc;
                    dir_d    = DIR_LEFT;
                    if (score2_inc == WIN) begin
                        state_d  = ST_OVER;
                        winner_d = 1'b1;
                    end else begin
                        state_d = ST_SERVE;
                        serve_d = 1'b1;
                    end
                end
            end

            ST_OVER: begin
                if (start_rise) begin
                    state_d  = ST_SERVE;
                    score1_d = '0;
                    score2_d = '0;
                    dir_d    = DIR_RIGHT;
                    winner_d = 1'b0;
                    serve_d  = 1'b1;
                end
`ifdef PONG_AUTO_RESTART_EN
                else if (i_frame_tick) begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d  = ST_IDLE;
                        score1_d = '0;
                        score2_d = '0;
                        winner_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
            end

            default: state_d = ST_IDLE;
        endcase

        // Every state change restarts the frame count, so SERVE and OVER
        // always begin counting from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            score1_q <= '0;
            score2_q <= '0;
            dir_q    <= DIR_RIGHT;
            winner_q <= 1'b0;
            serve_q  <= 1'b0;
            run_q    <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            dir_q    <= dir_d;
            winner_q <= winner_d;
            serve_q  <= serve_d;
            run_q    <= (state_d == ST_PLAY);
            over_q   <= (state_d == ST_OVER);
        end
    end

    assign o_ball_run   = run_q;
    assign o_ball_serve = serve_q;
    assign o_serve_dir  = dir_q;
    assign o_score1     = score1_q;
    assign o_score2     = score2_q;
    assign o_game_over  = over_q;
    assign o_winner     = winner_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
module tb_pong_match_ctrl;

    typedef struct packed {
        logic [1:0] state;
        logic       run;
        logic       serve;
        logic       dir;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       over;
        logic       winner;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       p1 = 1'b0;
    logic       p2 = 1'b0;
    logic       ball_run, ball_serve, serve_dir, game_over, winner;
    logic [3:0] score1, score2;
    logic [1:0] state;

    int unsigned checks = 0;
    int unsigned failures = 0;
    exp_t        sb_q[$];

    always #5 clk = ~clk;

    pong_match_ctrl #(
        .WIN_SCORE          (3),
        .SERVE_DELAY_FRAMES (3),
        .OVER_HOLD_FRAMES   (2)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_frame_tick (frame_tick),
        .i_start      (start),
        .i_point_p1   (p1),
        .i_point_p2   (p2),
        .o_ball_run   (ball_run),
        .o_ball_serve (ball_serve),
        .o_serve_dir  (serve_dir),
        .o_score1     (score1),
        .o_score2     (score2),
        .o_game_over  (game_over),
        .o_winner     (winner),
        .o_state      (state)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] st, input logic run, input logic srv,
                                input logic dir, input logic [3:0] s1, input logic [3:0] s2,
                                input logic ov, input logic win);
        exp_t e;
        e.state = st; e.run = run; e.serve = srv; e.dir = dir;
        e.s1 = s1; e.s2 = s2; e.over = ov; e.winner = win;
        return e;
    endfunction

    task automatic compare_front(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_state"},  state,      e.state);
        check({tag, "_run"},    ball_run,   e.run);
        check({tag, "_serve"},  ball_serve, e.serve);
        check({tag, "_dir"},    serve_dir,  e.dir);
        check({tag, "_score1"}, score1,     e.s1);
        check({tag, "_score2"}, score2,     e.s2);
        check({tag, "_over"},   game_over,  e.over);
        check({tag, "_winner"}, winner,     e.winner);
    endtask

    // Drive one cycle of inputs, push the expected post-edge outputs, then
    // compare just after the active edge.
    task automatic step(input string tag, input logic tk, input logic st,
                        input logic a, input logic b, input exp_t e);
        frame_tick = tk; start = st; p1 = a; p2 = b;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_front(tag);
        frame_tick = 1'b0; p1 = 1'b0; p2 = 1'b0;
    endtask

    // Three frame ticks from serve entry: frozen after two, running after the third.
    task automatic serve_wait(input string tag, input logic dir,
                              input logic [3:0] s1, input logic [3:0] s2);
        step({tag, "_t1"}, 1, start, 0, 0, mk(2'd1, 0, 0, dir, s1, s2, 0, 0));
        step({tag, "_t2"}, 1, start, 0, 0, mk(2'd1, 0, 0, dir, s1, s2, 0, 0));
        step({tag, "_t3"}, 1, start, 0, 0, mk(2'd2, 1, 0, dir, s1, s2, 0, 0));
    endtask

    initial begin
        // Reset with the button already held.
        start = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(mk(2'd0, 0, 0, 0, 0, 0, 0, 0));
        compare_front("reset");
        rst_n = 1'b1;

        step("held_start", 0, 1, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0));
        step("held_start2", 0, 1, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0));
        step("start_low", 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0));
        step("start_edge", 0, 1, 0, 0, mk(2'd1, 0, 1, 0, 0, 0, 0, 0));

        // Serve delay with a stray point in between.
        step("serve_t1", 1, 1, 0, 0, mk(2'd1, 0, 0, 0, 0, 0, 0, 0));
        step("serve_pt", 0, 1, 1, 1, mk(2'd1, 0, 0, 0, 0, 0, 0, 0));
        step("serve_pt1", 0, 1, 1, 0, mk(2'd1, 0, 0, 0, 0, 0, 0, 0));
        step("serve_t2", 1, 1, 0, 0, mk(2'd1, 0, 0, 0, 0, 0, 0, 0));
        step("serve_t3", 1, 1, 0, 0, mk(2'd2, 1, 0, 0, 0, 0, 0, 0));
        step("play_idle", 0, 1, 0, 0, mk(2'd2, 1, 0, 0, 0, 0, 0, 0));

        step("p2_point", 0, 1, 0, 1, mk(2'd1, 0, 1, 1, 0, 1, 0, 0));
        serve_wait("sw_a", 1, 0, 1);
        step("both_pts", 0, 1, 1, 1, mk(2'd1, 0, 1, 1, 0, 1, 0, 0));
        serve_wait("sw_b", 1, 0, 1);
        step("p1_pt1", 0, 1, 1, 0, mk(2'd1, 0, 1, 0, 1, 1, 0, 0));
        serve_wait("sw_c", 0, 1, 1);
        step("p1_pt2", 0, 1, 1, 0, mk(2'd1, 0, 1, 0, 2, 1, 0, 0));
        serve_wait("sw_d", 0, 2, 1);
        step("p1_win", 0, 1, 1, 0, mk(2'd3, 0, 0, 0, 3, 1, 1, 0));
        step("over_pt", 0, 1, 0, 1, mk(2'd3, 0, 0, 0, 3, 1, 1, 0));

`ifdef PONG_AUTO_RESTART_EN
        step("hold_t1", 1, 1, 0, 0, mk(2'd3, 0, 0, 0, 3, 1, 1, 0));
        step("hold_t2", 1, 1, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0));
        step("idle_low", 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0));
        step("restart", 0, 1, 0, 0, mk(2'd1, 0, 1, 0, 0, 0, 0, 0));
`else
        step("hold_t1", 1, 1, 0, 0, mk(2'd3, 0, 0, 0, 3, 1, 1, 0));
        step("hold_t2", 1, 1, 0, 0, mk(2'd3, 0, 0, 0, 3, 1, 1, 0));
        step("hold_t3", 1, 1, 0, 0, mk(2'd3, 0, 0, 0, 3, 1, 1, 0));
        step("over_low", 0, 0, 0, 0, mk(2'd3, 0, 0, 0, 3, 1, 1, 0));
        step("restart", 0, 1, 0, 0, mk(2'd1, 0, 1, 0, 0, 0, 0, 0));
`endif

        // Second game, then reset mid-PLAY at score1=2.
        serve_wait("g2_a", 0, 0, 0);
        step("g2_pt1", 0, 1, 1, 0, mk(2'd1, 0, 1, 0, 1, 0, 0, 0));
        serve_wait("g2_b", 0, 1, 0);
        step("g2_pt2", 0, 1, 1, 0, mk(2'd1, 0, 1, 0, 2, 0, 0, 0));
        step("g2_t1", 1, 1, 0, 0, mk(2'd1, 0, 0, 0, 2, 0, 0, 0));
        step("g2_t2", 1, 1, 0, 0, mk(2'd1, 0, 0, 0, 2, 0, 0, 0));
        step("g2_t3", 1, 1, 0, 0, mk(2'd2, 1, 0, 0, 2, 0, 0, 0));

        #3;
        rst_n = 1'b0;
        #1;
        sb_q.push_back(mk(2'd0, 0, 0, 0, 0, 0, 0, 0));
        compare_front("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Button still held through reset: no new game, pending count gone.
        step("post_rst", 1, 1, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0));
        step("post_rst2", 1, 1, 1, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0));

        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match-level sequencer for the Pong ball datapath: sits between the player start button, the ball block and the score display. It holds the ball frozen, recentres it for each serve, waits a serve delay, releases it, and counts points from the ball's exit events until one player reaches the winning score. It owns the authoritative score registers; the ball block only reports exits.

## Interface
- WIN_SCORE, 10, points needed to win; legal range 1..15.
- SERVE_DELAY_FRAMES, 60, frame ticks the ball stays frozen after a serve; ≥1.
- OVER_HOLD_FRAMES, 180, frame ticks in OVER before auto-restart (used only with the macro); ≥1.

- i_clk  in  1  pixel clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_frame_tick  in  1  one-cycle pulse per frame (pixel 0, line 481)
- i_start  in  1  start button, already synchronised and debounced, level
- i_point_p1  in  1  one-cycle pulse: ball exited right edge, player 1 scores
- i_point_p2  in  1  one-cycle pulse: ball exited left edge, player 2 scores
- o_ball_run  out  1  ball motion enable
- o_ball_serve  out  1  one-cycle pulse: ball recentres and takes o_serve_dir
- o_serve_dir  out  1  0 = right, 1 = left
- o_score1, o_score2  out  4  player scores
- o_game_over  out  1  high in OVER
- o_winner  out  1  0 = player 1, 1 = player 2; valid while o_game_over
- o_state  out  2  IDLE=0, SERVE=1, PLAY=2, OVER=3

## Operation
- Start event = rising edge of i_start (registered previous value; that register resets to 1, so a button held through reset does not start a game).
- IDLE: run=0, scores held at 0. Start event → SERVE, scores cleared, serve pulse, dir=0.
- SERVE: run=0; frame counter cleared on entry, increments on each i_frame_tick; on the tick where count == SERVE_DELAY_FRAMES−1 → PLAY.
- PLAY: run=1.
  - i_point_p1 alone: score1+1, dir=0 (serve toward conceding player 2).
  - i_point_p2 alone: score2+1, dir=1.
  - If the new score == WIN_SCORE → OVER, winner set, no serve pulse; otherwise → SERVE with serve pulse.
  - Both points in the same cycle: no score change, dir unchanged, → SERVE with serve pulse (replay).
- OVER: run=0, game_over=1, scores and winner held. Start event → SERVE, scores cleared, serve pulse, dir=0.
- Point pulses outside PLAY and start events in SERVE/PLAY are ignored.
- Scores are 4-bit and never exceed WIN_SCORE, so no wrap occurs.

## Timing
- All outputs are registered. Reset values: state IDLE, run 0, serve 0, dir 0, scores 0, game_over 0, winner 0, frame counter 0.
- Latency is 1 cycle from a qualifying input (start edge or point pulse) to the state, score and serve-pulse update.
- o_ball_serve is high for exactly one cycle per serve.
- o_ball_run rises in the cycle after the final delay tick.
- Frame counter width is $clog2 of the larger of the two frame parameters, plus 1.
- Reset asserted mid-game forces IDLE immediately (asynchronous) and discards any pending delay count.

## Configuration
- PONG_AUTO_RESTART_EN defined:
  - OVER counts frame ticks from entry.
  - On the tick where count == OVER_HOLD_FRAMES−1 → IDLE, scores cleared.
  - A start event before that tick still goes → SERVE.
- Undefined: OVER is left only by a start event, and OVER_HOLD_FRAMES is unused.

## Structure
- Shared package pong_pkg holds:
  - the state enum (IDLE/SERVE/PLAY/OVER);
  - direction constants DIR_RIGHT=0 and DIR_LEFT=1, shared with the ball block.
- One sub-module: pong_rise_detect (registered rising-edge detector, configurable reset value), used for i_start.

## Test plan
- Reset with i_start held high, then release reset → stays IDLE and scores 0. Drop i_start, raise it again → SERVE next cycle, one-cycle o_ball_serve, o_serve_dir=0.
- SERVE_DELAY_FRAMES=3: after the start event, give 3 frame ticks → o_ball_run=1 only after the 3rd tick. Point pulses during SERVE leave the scores at 0.
- In PLAY, pulse i_point_p2 → score2=1, o_serve_dir=1, state SERVE, serve pulse. Pulse both point inputs together → scores unchanged, state SERVE.
- WIN_SCORE=3: three i_point_p1 wins → after the third pulse, state OVER, o_game_over=1, o_winner=0, score1=3, no serve pulse. A further point pulse is ignored.
- In OVER, give a start event → SERVE with scores 0. With PONG_AUTO_RESTART_EN and OVER_HOLD_FRAMES=2: 2 ticks in OVER → IDLE with scores 0.
- Assert i_reset_n low mid-PLAY with score1=2 → immediately IDLE, all outputs at their reset values.
